hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It is the producing end of the flush/stall protocol that the IF/ID and ID/EX pipeline registers consume. It detects load-use hazards, taken branches/jumps resolved in EX, and structural hazards on a multi-cycle multiply/divide unit. It drives `pc_write`, `if_id_write`, `if_id_flush` and `id_ex_flush` so that the downstream registers insert bubbles or squash wrong-path instructions.

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_md_busy_tracker.sv | 53 +++++
 rtl/hazard_ctrl.sv | 95 +++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller and the pipeline registers that consume its
// flush/stall controls.
package hazard_ctrl_pkg;

    localparam logic ID_EX_FLUSH_ON  = 1'b1;
    localparam logic ID_EX_FLUSH_OFF = 1'b0;
    localparam logic IF_ID_FLUSH_ON  = 1'b1;
    localparam logic IF_ID_FLUSH_OFF = 1'b0;
    localparam logic DM_R_ON         = 1'b1;

    localparam int unsigned MdCntW = 6;

    typedef enum logic {
        HazRun    = 1'b0,
        HazMdBusy = 1'b1
    } haz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } haz_ctrl_t;

    // A load in EX whose destination feeds either ID source; $0 never creates a dependency.
    function automatic logic load_use_hit(input logic       dm_r,
                                          input logic [4:0] ex_rt,
                                          input logic [4:0] id_rs,
                                          input logic [4:0] id_rt);
        return (dm_r == DM_R_ON) && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: HazRun/HazMdBusy FSM plus the
// 6-bit down-counter md_cnt.
module md_busy_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic issue_i,
    output logic md_busy_o
);

    localparam logic [MdCntW-1:0] CntInit = MdCntW'(MD_LATENCY - 1);

    haz_state_e        state_q, state_d;
    logic [MdCntW-1:0] md_cnt_q, md_cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HazRun;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            HazRun: begin
                if (issue_i) begin
                    md_cnt_d = CntInit;
                    state_d  = HazMdBusy;
                end
            end
            HazMdBusy: begin
                if (md_cnt_q == '0) begin
                    state_d = HazRun;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        md_busy_o = (state_q == HazMdBusy);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: flush > load-use > md-stall priority driving the IF/ID and ID/EX
// register controls. Define HAZARD_PERF_EN to build the saturating stall_count perf counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_instruction,
    input  logic [31:0] id_ex_instruction,
    input  logic        id_ex_dm_r,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        md_read,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    logic [4:0] id_rs, id_rt, ex_rt;
    logic       load_use, md_stall, md_issue, md_busy_raw;
    haz_ctrl_t  ctrl;

    assign id_rs = if_id_instruction[25:21];
    assign id_rt = if_id_instruction[20:16];
    assign ex_rt = id_ex_instruction[20:16];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{if_id_instruction[31:26], if_id_instruction[15:0],
                                 id_ex_instruction[31:21], id_ex_instruction[15:0]};

    assign load_use = load_use_hit(id_ex_dm_r, ex_rt, id_rs, id_rt);
    assign md_stall = md_busy_raw && (md_start || md_read);
    // A flushed or load-stalled mult/div stays in ID, so it must not start the unit yet.
    assign md_issue = md_start && !branch_taken && !load_use;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_tracker (
        .clk_i     (clk),
        .rst_ni    (reset),
        .issue_i   (md_issue),
        .md_busy_o (md_busy_raw)
    );

    always_comb begin
        ctrl = '{pc_write: 1'b1, if_id_write: 1'b1,
                 if_id_flush: IF_ID_FLUSH_OFF, id_ex_flush: ID_EX_FLUSH_OFF};
        if (!reset) begin
            ctrl = '{pc_write: 1'b0, if_id_write: 1'b0,
                     if_id_flush: IF_ID_FLUSH_ON, id_ex_flush: ID_EX_FLUSH_ON};
        end else if (branch_taken) begin
            ctrl.if_id_flush = IF_ID_FLUSH_ON;
            ctrl.id_ex_flush = ID_EX_FLUSH_ON;
        end else if (load_use || md_stall) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_flush = ID_EX_FLUSH_ON;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign if_id_write = ctrl.if_id_write;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign md_busy     = md_busy_raw && reset;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (!ctrl.pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_LATENCY=4): table-driven single-cycle vectors plus
// hand-written multi-cycle sequences, all checked through an expected-value queue.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_instruction, id_ex_instruction;
    logic        id_ex_dm_r, branch_taken, md_start, md_read;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;
    logic [15:0] stall_count;

    hazard_ctrl #(
        .MD_LATENCY (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_id_instruction (if_id_instruction),
        .id_ex_instruction (id_ex_instruction),
        .id_ex_dm_r        (id_ex_dm_r),
        .branch_taken      (branch_taken),
        .md_start          (md_start),
        .md_read           (md_read),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .md_busy           (md_busy),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy}
    localparam logic [4:0] RUN     = 5'b11000;
    localparam logic [4:0] RUN_B   = 5'b11001;
    localparam logic [4:0] STALL   = 5'b00010;
    localparam logic [4:0] STALL_B = 5'b00011;
    localparam logic [4:0] FLUSH   = 5'b11110;
    localparam logic [4:0] FLUSH_B = 5'b11111;
    localparam logic [4:0] IN_RST  = 5'b00110;

    typedef struct {
        logic [31:0] id_i;
        logic [31:0] ex_i;
        logic        dm_r;
        logic        br;
        logic        ms;
        logic        mr;
        logic [4:0]  exp;
        string       name;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;
    logic [4:0] exp_q[$];
    string      name_q[$];
    vec_t       vecs[12];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rt);
        return {6'h23, 5'd0, rt, 16'd0};
    endfunction

    function automatic vec_t mk(input logic [31:0] id_i, input logic [31:0] ex_i,
                                input logic dm_r, input logic br, input logic ms,
                                input logic mr, input logic [4:0] exp, input string name);
        vec_t v;
        v.id_i = id_i; v.ex_i = ex_i; v.dm_r = dm_r; v.br = br;
        v.ms = ms; v.mr = mr; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        if_id_instruction = v.id_i;
        id_ex_instruction = v.ex_i;
        id_ex_dm_r        = v.dm_r;
        branch_taken      = v.br;
        md_start          = v.ms;
        md_read           = v.mr;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
    endtask

    task automatic check_out();
        logic [4:0] e, got;
        string      n;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        got = {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy};
        if (md_busy === 1'b1) busy_seen++;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b (pc_wr,ifid_wr,ifid_fl,idex_fl,busy)", n, got, e);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check_out();
    endtask

    task automatic check_count(input string n, input logic [15:0] want);
        checks++;
        if (stall_count !== want) begin
            errors++;
            $display("FAIL %s: stall_count got %h want %h", n, stall_count, want);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] add_657, add_357, add_000, mult_89, mfhi_0, lw5, lw0, lw9;
        add_657 = rtype(5'd5, 5'd7, 5'd6);
        add_357 = rtype(5'd3, 5'd5, 5'd7);
        add_000 = rtype(5'd0, 5'd0, 5'd6);
        mult_89 = rtype(5'd8, 5'd9, 5'd0);
        mfhi_0  = rtype(5'd0, 5'd0, 5'd10);
        lw5 = lw(5'd5);
        lw0 = lw(5'd0);
        lw9 = lw(5'd9);

        vecs[0]  = mk(add_657, lw5, 1'b0, 1'b0, 1'b0, 1'b0, RUN,   "no_load");
        vecs[1]  = mk(add_657, lw5, 1'b1, 1'b0, 1'b0, 1'b0, STALL, "load_use_rs");
        vecs[2]  = mk(add_657, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, "load_use_released");
        vecs[3]  = mk(add_357, lw5, 1'b1, 1'b0, 1'b0, 1'b0, STALL, "load_use_rt");
        vecs[4]  = mk(add_000, lw0, 1'b1, 1'b0, 1'b0, 1'b0, RUN,   "load_rt_zero");
        vecs[5]  = mk(add_657, lw9, 1'b1, 1'b0, 1'b0, 1'b0, RUN,   "load_no_match");
        vecs[6]  = mk(add_657, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, FLUSH, "branch");
        vecs[7]  = mk(add_657, lw5, 1'b1, 1'b1, 1'b0, 1'b0, FLUSH, "branch_over_load_use");
        vecs[8]  = mk(mfhi_0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, RUN,  "md_read_idle");
        vecs[9]  = mk(mult_89, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, FLUSH, "md_start_flushed");
        vecs[10] = mk(mult_89, lw9, 1'b1, 1'b0, 1'b1, 1'b0, STALL, "md_start_load_use");
        vecs[11] = mk(mfhi_0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, RUN,  "no_issue_after_block");

        drive(mk(add_657, lw5, 1'b1, 1'b0, 1'b1, 1'b0, IN_RST, "reset_forced"));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out();
        check_count("stall_count_reset", 16'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // MD occupancy: issue, then a dependent mfhi waits out all four busy cycles.
        step(mk(mult_89, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, RUN, "md_issue"));
        busy_seen = 0;
        for (int i = 1; i <= 4; i++)
            step(mk(mfhi_0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, STALL_B, "md_read_stall"));
        step(mk(mfhi_0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, "md_read_release"));
        checks++;
        if (busy_seen != 4) begin
            errors++;
            $display("FAIL md_busy_len: got %0d want 4", busy_seen);
        end

        // Back-to-back: second mult stalls while busy, issues in the first HazRun cycle.
        busy_seen = 0;
        step(mk(mult_89, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, RUN, "b2b_issue1"));
        step(mk(mult_89, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, FLUSH_B, "b2b_branch_while_busy"));
        for (int i = 2; i <= 4; i++)
            step(mk(mult_89, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL_B, "b2b_stall"));
        step(mk(mult_89, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, RUN, "b2b_issue2"));
        for (int i = 1; i <= 4; i++)
            step(mk(add_657, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN_B, "b2b_busy2"));
        step(mk(add_657, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, "b2b_done"));
        checks++;
        if (busy_seen != 8) begin
            errors++;
            $display("FAIL b2b_busy_total: got %0d want 8", busy_seen);
        end

        // Reset while md_cnt == 2 (second busy cycle).
        step(mk(mult_89, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, RUN, "rst_issue"));
        step(mk(add_657, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN_B, "rst_busy_cnt3"));
        step(mk(mfhi_0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, STALL_B, "rst_busy_cnt2"));
        #2 reset = 1'b0;
        exp_q.push_back(IN_RST);
        name_q.push_back("rst_mid_op");
        #1 check_out();
        @(posedge clk);
        #1 reset = 1'b1;
        step(mk(mfhi_0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, "rst_released_no_stall"));

`ifdef HAZARD_PERF_EN
        @(posedge clk);
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        step(mk(add_657, lw5, 1'b1, 1'b0, 1'b0, 1'b0, STALL, "perf_lu1"));
        step(mk(add_657, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, FLUSH, "perf_fl1"));
        step(mk(add_357, lw5, 1'b1, 1'b0, 1'b0, 1'b0, STALL, "perf_lu2"));
        step(mk(add_657, lw5, 1'b1, 1'b1, 1'b0, 1'b0, FLUSH, "perf_fl2"));
        step(mk(add_657, lw5, 1'b1, 1'b0, 1'b0, 1'b0, STALL, "perf_lu3"));
        step(mk(add_657, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, "perf_run"));
        check_count("perf_three_stalls", 16'd3);
        @(posedge clk);
        #1 drive(mk(add_657, lw5, 1'b1, 1'b0, 1'b0, 1'b0, STALL, "perf_sat_stall"));
        repeat (65531) @(posedge clk);
        @(negedge clk);
        check_out();
        check_count("perf_near_sat", 16'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_count("perf_saturated", 16'hFFFF);
`else
        check_count("stall_count_tied", 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
